// File: rtl/led_out_pio_pkg.sv
// Shared constants for led_out_pio: register word offsets and bus data width.
package led_out_pio_pkg;

    localparam int unsigned RDATA_W = 32;

    typedef enum logic [2:0] {
        ADDR_DATA       = 3'd0,
        ADDR_BLINK_MASK = 3'd1,
        ADDR_PRESCALE   = 3'd2,
        ADDR_OUTSET     = 3'd4,
        ADDR_OUTCLEAR   = 3'd5
    } reg_addr_e;

endpackage

// File: rtl/led_out_pio_blink_timer.sv
// Blink prescaler: down-counter that toggles phase every PRESCALE+1 cycles.
// prescale carries the value PRESCALE will hold after this edge (new data on a write).
module led_out_pio_blink_timer #(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  prescale_wr,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (prescale_wr) begin
            // A rewrite restarts the count; phase survives unless blinking is turned off.
            cnt <= prescale;
            if (prescale == '0)
                phase <= 1'b0;
        end else if (prescale == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= prescale;
            phase <= ~phase;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/led_out_pio.sv
// Avalon-MM output PIO with atomic set/clear and per-bit blinking.
// Define LED_OUT_PIO_ACTIVE_LOW_EN to drive out_port inverted (readback stays active-high).
module led_out_pio
    import led_out_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       PRESCALE_W  = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [RDATA_W-1:0] readdata,
    output logic [WIDTH-1:0]   out_port
);

    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      blink_mask_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_nxt;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      out_val;
    logic [RDATA_W-1:0]    rd_mux;
    logic                  wr;
    logic                  prescale_wr;
    logic                  phase;
    logic                  unused_wdata;

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign prescale_wr  = wr && (address == ADDR_PRESCALE);
    assign prescale_nxt = prescale_wr ? writedata[PRESCALE_W-1:0] : prescale_q;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= RESET_VALUE;
            blink_mask_q <= '0;
            prescale_q   <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:       data_q       <= wdata;
                ADDR_BLINK_MASK: blink_mask_q <= wdata;
                ADDR_PRESCALE:   prescale_q   <= writedata[PRESCALE_W-1:0];
                ADDR_OUTSET:     data_q       <= data_q | wdata;
                ADDR_OUTCLEAR:   data_q       <= data_q & ~wdata;
                default: ;
            endcase
        end
    end

    led_out_pio_blink_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_blink_timer (
        .clk         (clk),
        .reset       (reset),
        .prescale    (prescale_nxt),
        .prescale_wr (prescale_wr),
        .phase       (phase)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:       rd_mux[WIDTH-1:0]      = data_q;
            ADDR_BLINK_MASK: rd_mux[WIDTH-1:0]      = blink_mask_q;
            ADDR_PRESCALE:   rd_mux[PRESCALE_W-1:0] = prescale_q;
            default: ;
        endcase
    end

    assign out_val = data_q ^ (blink_mask_q & {WIDTH{phase}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
`ifdef LED_OUT_PIO_ACTIVE_LOW_EN
            out_port <= ~RESET_VALUE;
`else
            out_port <= RESET_VALUE;
`endif
        end else begin
            readdata <= rd_mux;
`ifdef LED_OUT_PIO_ACTIVE_LOW_EN
            out_port <= ~out_val;
`else
            out_port <= out_val;
`endif
        end
    end

endmodule
